// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT control.
// Fetches sequentially until the PC runs past the end of instruction memory.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        if_id_valid,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CNTW = 32;
  localparam logic [XLEN-1:0] LAST_PC  = XLEN'(IMEM_BYTES) - XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN    = ~XLEN'(3);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_d;
  logic              valid_d;
  logic [XLEN-1:0]   if_pc_d;
  logic [ILEN-1:0]   if_instr_d;
  logic [CNTW-1:0]   count_d;
  logic              halted_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_addr     <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      fetch_count <= '0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_addr     <= pc_d;
      if_id_valid <= valid_d;
      if_id_pc    <= if_pc_d;
      if_id_instr <= if_instr_d;
      fetch_count <= count_d;
      halted      <= halted_d;
    end
  end

  // Next-state: redirect beats stall beats the end-of-memory check
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_addr;
    valid_d    = if_id_valid;
    if_pc_d    = if_id_pc;
    if_instr_d = if_id_instr;
    count_d    = fetch_count;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_d       = branch_target & ALIGN;
          valid_d    = 1'b0;
          if_pc_d    = '0;
          if_instr_d = '0;
        end else if (!stall) begin
          if (pc_addr <= LAST_PC) begin
            if_pc_d    = pc_addr;
            if_instr_d = instruction;
            valid_d    = 1'b1;
            pc_d       = pc_addr + XLEN'(4);
            count_d    = (fetch_count == CNT_MAX) ? fetch_count : fetch_count + CNTW'(1);
          end else begin
            valid_d = 1'b0;
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic checked against a behavioural fetch model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [63:0] pc_addr;
  logic [31:0] instruction;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        halted;
  logic [31:0] fetch_count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem [16];

  // Behavioural model state
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_ifpc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  logic        m_halt;

  fetch_stage #(.RESET_PC(64'h0), .IMEM_BYTES(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_addr       (pc_addr),
    .instruction   (instruction),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 16 words, out-of-range reads return all ones
  assign instruction = (pc_addr < 64'd64) ? mem[pc_addr[5:2]] : 32'hFFFF_FFFF;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return (a < 64'd64) ? mem[a[5:2]] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc_addr,            m_pc);
    chk({tag, ".valid"},  64'(if_id_valid),   64'(m_valid));
    chk({tag, ".ifpc"},   if_id_pc,           m_ifpc);
    chk({tag, ".instr"},  64'(if_id_instr),   64'(m_instr));
    chk({tag, ".halted"}, 64'(halted),        64'(m_halt));
    chk({tag, ".count"},  64'(fetch_count),   64'(m_count));
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_valid = 1'b0; m_ifpc = 64'h0; m_instr = 32'h0;
    m_count = 32'h0; m_halt = 1'b0;
  endtask

  // One clock of the fetch rules
  task automatic model_step(input logic st, input logic br, input logic [63:0] tgt);
    if (m_halt) begin
      m_valid = 1'b0;
    end else if (br) begin
      m_pc = (tgt / 4) * 4;
      m_valid = 1'b0; m_ifpc = 64'h0; m_instr = 32'h0;
    end else if (!st) begin
      if (m_pc + 4 <= 64 && m_pc < 64) begin
        m_ifpc = m_pc; m_instr = imem_word(m_pc); m_valid = 1'b1;
        m_pc = m_pc + 4;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end else begin
        m_valid = 1'b0; m_halt = 1'b1;
      end
    end
  endtask

  // Called just after a negedge: drive, clock, compare
  task automatic cycle(input string tag, input logic st, input logic br, input logic [63:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    model_step(st, br, tgt);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] tgt;
    logic        st, br;

    rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h8B02_0020;
    mem[1] = 32'hCB03_0041;
    #2;
    do_reset("reset0");

    // Sequential fetch of the first two words
    cycle("seq1", 1'b0, 1'b0, 64'h0);
    chk("seq1.instr_const", 64'(if_id_instr), 64'h8B02_0020);
    chk("seq1.pc_const",    pc_addr,          64'h4);
    cycle("seq2", 1'b0, 1'b0, 64'h0);
    chk("seq2.ifpc_const",  if_id_pc,         64'h4);
    chk("seq2.instr_const", 64'(if_id_instr), 64'hCB03_0041);
    chk("seq2.count_const", 64'(fetch_count), 64'd2);

    // Three stalled cycles at pc 8, then capture of address 8
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 64'h0);
    chk("stall.pc_const", pc_addr, 64'h8);
    cycle("stall_rel", 1'b0, 1'b0, 64'h0);
    chk("stall_rel.ifpc_const", if_id_pc, 64'h8);

    // Redirect beats a simultaneous stall, target realigned
    cycle("redir", 1'b1, 1'b1, 64'h2E);
    chk("redir.pc_const", pc_addr, 64'h2C);
    cycle("redir_cap", 1'b0, 1'b0, 64'h0);
    chk("redir_cap.ifpc_const", if_id_pc, 64'h2C);

    // Run to end of memory, halt, then redirect is ignored
    do_reset("reset_eom");
    for (int i = 0; i < 16; i++) cycle("eom_run", 1'b0, 1'b0, 64'h0);
    chk("eom.pc_const",    pc_addr,          64'd64);
    chk("eom.count_const", 64'(fetch_count), 64'd16);
    cycle("eom_halt", 1'b0, 1'b0, 64'h0);
    chk("eom.halted_const", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) cycle("halt_ign", i[0], 1'b1, 64'h10);

    // Asynchronous reset between edges while halted
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Redirect taken at the boundary PC prevents the halt
    for (int i = 0; i < 16; i++) cycle("bnd_run", 1'b0, 1'b0, 64'h0);
    cycle("bnd_redir", 1'b0, 1'b1, 64'h10);
    chk("bnd.pc_const",     pc_addr,      64'h10);
    chk("bnd.halted_const", 64'(halted),  64'd0);
    cycle("bnd_cap", 1'b0, 1'b0, 64'h0);

    // Randomized stall/redirect traffic, reset between rounds
    for (int r = 0; r < 6; r++) begin
      do_reset("rnd_reset");
      for (int i = 0; i < 60; i++) begin
        st = ($urandom_range(0, 3) == 0);
        br = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) tgt = {$urandom, $urandom};
        else tgt = 64'($urandom_range(0, 72));
        cycle("rnd", st, br, tgt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
